sampler_trig: RTL
=================

# sampler_trig

Parametrised triggered sampler, the successor to the fixed 8-channel free-running sampler in the logic-analyzer capture path. It synchronises CH asynchronous probe inputs and samples them at a programmable rate derived from `clk`. It arms on command, waits for a masked level/edge trigger pattern, then emits the trigger sample plus a programmed number of post-trigger samples through a valid/ready output register. Downstream it feeds the capture buffer/uploader; upstream it is configured by the control register block.

## Interface
- `CH`, 8, number of probe channels
- `SYNC_STAGES`, 2, input synchroniser depth (≥2)
- `DIV_W`, 16, width of sample-period divider
- `CNT_W`, 16, width of post-trigger sample count
- `clk`  in  1  sampling clock (27 MHz)
- `reset`  in  1  asynchronous, active-high reset
- `data_in`  in  CH  asynchronous probe inputs
- `arm`  in  1  single-cycle pulse: latch config, start acquisition
- `abort`  in  1  single-cycle pulse: return to IDLE
- `div`  in  DIV_W  sample period minus 1 (0 = sample every clk)
- `trig_mask`  in  CH  1 = channel participates in trigger
- `trig_value`  in  CH  required level; edge polarity (1 = rising)
- `trig_edge`  in  CH  1 = edge match, 0 = level match
- `post_count`  in  CNT_W  samples emitted after the trigger sample
- `data_out`  out  CH  captured sample
- `valid`  out  1  `data_out` holds an unconsumed sample
- `ready`  in  1  consumer accepts `data_out` when `valid & ready`
- `busy`  out  1  state is ARMED or CAPTURE
- `triggered`  out  1  trigger has fired in current acquisition
- `done`  out  1  state is DONE
- `overflow`  out  1  sticky: a sample was dropped because the output was full

## Operation
- Synchroniser: SYNC_STAGES flops per channel, reset to 0; all logic uses the synchronised value `s`.
- Config (`div`, `trig_*`, `post_count`) is latched on an accepted `arm`; later changes have no effect until the next arm.
- Divider: counter runs only in ARMED/CAPTURE; cleared to 0 on arm. `tick` asserts when counter == latched div, then counter returns to 0. With div=N, ticks occur every N+1 clks; the first tick is N+1 clks after arm.
- `prev` register holds the previous ticked sample; it is loaded with `s` on arm and updated on every tick.
- Per-channel match: level: `s==value`; edge: `s==value && prev!=value`. trigger = AND of matches over masked channels; mask all-zero → trigger on the first tick.
- States:
  - IDLE: `arm` → ARMED.
  - ARMED: on a tick with trigger, emit `s`, load remaining = post_count, set `triggered`. If post_count = 0 go to DONE, else go to CAPTURE. Non-trigger ticks emit nothing.
  - CAPTURE: each tick emits `s` and decrements remaining; when remaining reaches 0 after the emit, go to DONE. Total emitted = post_count + 1.
  - DONE: `arm` → ARMED.
- `arm` while ARMED/CAPTURE is ignored. `abort` in any state → IDLE, clears `valid`, keeps `overflow`/`triggered` until next arm. Simultaneous `arm` and `abort`: abort wins.
- Accepted arm clears `triggered`, `overflow` and `valid`.
- Emit: if `valid & ~ready` in the emit cycle, the sample is dropped, `data_out` is unchanged, `overflow` is set, and the remaining count still decrements. Otherwise `data_out` ← `s` and `valid` ← 1.
- `valid` clears on a `valid & ready` cycle with no simultaneous emit. Emit and accept in the same cycle: new data is loaded and `valid` stays 1.
- `valid` may remain high in DONE until consumed.

## Timing
- Reset values: `data_out`=0, `valid`=0, `busy`=0, `triggered`=0, `done`=0, `overflow`=0, state IDLE, divider 0, synchroniser 0.
- Input to `s` latency: SYNC_STAGES clks.
- Emit on tick at edge k: `data_out`/`valid` updated at edge k+1. Status outputs are registered and track the state one edge after the transition condition.
- Trigger evaluation is combinational on `s`/`prev` at the tick cycle; no extra latency.
- Reset mid-acquisition: all outputs return to reset values immediately (asynchronous).

## Test plan
- Reset during CAPTURE with `valid`=1 → all outputs 0 immediately; state IDLE.
- div=0, mask=0x00, post_count=3, ready=1 → 4 consecutive samples, `valid` pulses on 4 successive clks, then `done`=1, `busy`=0.
- div=2, mask=0x01, edge=0x01, value=0x01, ch0 rises at sample 5 → first `data_out` has ch0=1; emits spaced 3 clks apart; `triggered`=1.
- Level trigger value=0xA5, mask=0xFF, ARMED with input 0x5A, then 0xA5 → no emit until 0xA5 is ticked; trigger sample = 0xA5.
- ready=0, post_count=2, div=0 → first sample held in `data_out`, next 2 dropped, `overflow`=1, DONE reached; next `arm` clears `overflow`.
- `arm` and `abort` in the same cycle from IDLE → remains IDLE; `abort` during CAPTURE → IDLE, `valid`=0.

Source files
------------

// File: rtl/sampler_trig.sv
// ============================================================================
// sampler_trig
// ----------------------------------------------------------------------------
// Triggered logic-analyzer sampler. It synchronises CH asynchronous probe
// inputs and samples them at a programmable rate derived from clk. An arm
// pulse latches the configuration and starts an acquisition. The block then
// waits for a masked level/edge trigger pattern and emits the trigger sample
// plus post_count further samples through a valid/ready output register.
//
// Parameters
//   CH          number of probe channels
//   SYNC_STAGES input synchroniser depth (>= 2)
//   DIV_W       width of the sample-period divider
//   CNT_W       width of the post-trigger sample count
//
// Ports
//   clk          sampling clock
//   reset        asynchronous, active-high reset
//   data_in      asynchronous probe inputs
//   arm          pulse: latch config, start acquisition (IDLE/DONE only)
//   abort        pulse: return to IDLE (wins over arm)
//   div          sample period minus 1
//   trig_mask    1 = channel participates in the trigger
//   trig_value   required level, or edge polarity (1 = rising)
//   trig_edge    1 = edge match, 0 = level match
//   post_count   samples emitted after the trigger sample
//   data_out     captured sample
//   valid        data_out holds an unconsumed sample
//   ready        consumer takes data_out when valid & ready
//   busy         acquisition in progress (ARMED or CAPTURE)
//   triggered    trigger has fired in the current acquisition
//   done         acquisition complete
//   overflow     sticky: a sample was dropped because the output was full
// ============================================================================
module sampler_trig #(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH-1:0]    data_in,
    input  logic             arm,
    input  logic             abort,
    input  logic [DIV_W-1:0] div,
    input  logic [CH-1:0]    trig_mask,
    input  logic [CH-1:0]    trig_value,
    input  logic [CH-1:0]    trig_edge,
    input  logic [CNT_W-1:0] post_count,
    output logic [CH-1:0]    data_out,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             triggered,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t state_reg;

    // ------------------------------------------------------------------
    // Input synchroniser: stage 0 takes data_in, the last stage is the
    // sampled value every other piece of logic looks at.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][CH-1:0] sync_reg;
    logic [CH-1:0]                  s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], data_in};
        end
    end

    assign s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Latched configuration (only an accepted arm updates it)
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_reg;
    logic [CH-1:0]    mask_reg;
    logic [CH-1:0]    value_reg;
    logic [CH-1:0]    edge_reg;
    logic [CNT_W-1:0] post_reg;

    logic active;
    logic arm_ok;

    assign active = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
    assign arm_ok = arm && !abort &&
                    ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg   <= '0;
            mask_reg  <= '0;
            value_reg <= '0;
            edge_reg  <= '0;
            post_reg  <= '0;
        end else if (arm_ok) begin
            div_reg   <= div;
            mask_reg  <= trig_mask;
            value_reg <= trig_value;
            edge_reg  <= trig_edge;
            post_reg  <= post_count;
        end
    end

    // ------------------------------------------------------------------
    // Sample-rate divider. Counts 0..div_reg while acquiring; the tick
    // fires on the terminal count so the first tick lands div+1 clks
    // after the arm edge.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;

    assign tick = active && (div_cnt_reg == div_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= '0;
        end else if (abort || arm_ok) begin
            div_cnt_reg <= '0;
        end else if (active) begin
            if (tick) begin
                div_cnt_reg <= '0;
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end
        end
    end

    // Previous ticked sample, seeded at arm so an input that is already
    // at the edge-target level does not count as an edge.
    logic [CH-1:0] prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg <= '0;
        end else if (arm_ok || tick) begin
            prev_reg <= s;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel trigger match. An unmasked channel always matches, so
    // an all-zero mask fires on the first tick.
    // ------------------------------------------------------------------
    logic [CH-1:0] ch_hit;
    logic          trig_hit;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_match
            logic level_ok;
            logic edge_ok;
            assign level_ok    = (s[gi] == value_reg[gi]);
            assign edge_ok     = (prev_reg[gi] != value_reg[gi]);
            assign ch_hit[gi]  = !mask_reg[gi] ||
                                 (level_ok && (!edge_reg[gi] || edge_ok));
        end
    endgenerate

    assign trig_hit = &ch_hit;

    // A sample is emitted on the trigger tick and on every capture tick.
    logic emit;

    assign emit = !abort && tick &&
                  (((state_reg == ST_ARMED) && trig_hit) ||
                   (state_reg == ST_CAPTURE));

    // ------------------------------------------------------------------
    // Control FSM with registered status outputs
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] remaining_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            triggered     <= 1'b0;
        end else if (abort) begin
            // triggered is kept so software can see why it was aborted
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (arm_ok) begin
                        state_reg <= ST_ARMED;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        triggered <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (tick && trig_hit) begin
                        triggered     <= 1'b1;
                        remaining_reg <= post_reg;
                        if (post_reg == '0) begin
                            state_reg <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    // remaining is never 0 here; the last emit happens
                    // while it still reads 1.
                    if (tick) begin
                        remaining_reg <= remaining_reg - CNT_W'(1);
                        if (remaining_reg == CNT_W'(1)) begin
                            state_reg <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register. A full, unaccepted register drops the new sample
    // and flags overflow; data_out keeps the older sample.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (abort) begin
            valid <= 1'b0;
        end else if (arm_ok) begin
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (emit) begin
            if (valid && !ready) begin
                overflow <= 1'b1;
            end else begin
                data_out <= s;
                valid    <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule
